// File: rtl/gcd_job_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : gcd_job_scheduler
//  Description : Avalon-MM master that time-shares one GCD calculator CSR
//                slave among NUM_REQ requesters. Jobs are granted
//                round-robin. Each job writes A, then B (which starts the
//                slave), polls status until it reads zero, reads the result
//                and returns it on one tagged response channel. Jobs with a
//                zero operand are answered locally as a|b.
//  Ports       : clock, reset_n        - clock, async active-low reset
//                req_valid/req_ready    - per-requester job handshake
//                req_a/req_b            - packed operands, 32 bits per port
//                rsp_valid/rsp_ready    - result handshake
//                rsp_id/rsp_gcd         - owner tag and GCD value
//                avm_*                  - Avalon-MM master to the slave
//                busy                   - low only while idle
//                jobs_done              - accepted responses, wraps
//  Revision    : 1.0 - initial release
// ============================================================================
module gcd_job_scheduler #(
  parameter int NUM_REQ  = 2,
  parameter int ID_W     = $clog2(NUM_REQ),
  parameter int POLL_GAP = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [32*NUM_REQ-1:0] req_a,
  input  logic [32*NUM_REQ-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           rsp_gcd,
  output logic                  avm_read,
  output logic                  avm_write,
  output logic [1:0]            avm_address,
  output logic [31:0]           avm_writedata,
  input  logic [31:0]           avm_readdata,
  output logic                  busy,
  output logic [15:0]           jobs_done
);

  localparam int c_GAP_W = (POLL_GAP < 2) ? 1 : $clog2(POLL_GAP);
  localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);
  localparam logic [1:0] c_ADDR_STATUS = 2'd0;
  localparam logic [1:0] c_ADDR_A      = 2'd1;
  localparam logic [1:0] c_ADDR_B      = 2'd2;

  // S_INIT is a one-cycle holding state so that every bus strobe leaves
  // reset low; the status-poll loop proper starts in S_INIT_RD.
  typedef enum logic [3:0] {
    S_INIT     = 4'd0,
    S_INIT_RD  = 4'd1,
    S_INIT_CHK = 4'd2,
    S_INIT_GAP = 4'd3,
    S_IDLE     = 4'd4,
    S_WR_A     = 4'd5,
    S_WR_B     = 4'd6,
    S_POLL_RD  = 4'd7,
    S_POLL_CHK = 4'd8,
    S_GAP      = 4'd9,
    S_RES_RD   = 4'd10,
    S_RES_CHK  = 4'd11,
    S_RESP     = 4'd12
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [ID_W-1:0]    r_ptr;
  logic [ID_W-1:0]    r_id;
  logic [31:0]        r_b;
  logic [31:0]        r_gcd;
  logic [c_GAP_W-1:0] r_cnt;

  logic               w_found;
  logic [ID_W-1:0]    w_sel;
  logic [31:0]        w_a;
  logic [31:0]        w_b;
  logic               w_zero;
  logic               w_slave_busy;

  // Round-robin search from r_ptr+1: first the ports above the pointer,
  // then wrap around to the ports at or below it.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_a     = '0;
    w_b     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && req_valid[i] && (i > int'(r_ptr))) begin
        w_found = 1'b1;
        w_sel   = ID_W'(i);
        w_a     = req_a[32*i +: 32];
        w_b     = req_b[32*i +: 32];
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && req_valid[i] && (i <= int'(r_ptr))) begin
        w_found = 1'b1;
        w_sel   = ID_W'(i);
        w_a     = req_a[32*i +: 32];
        w_b     = req_b[32*i +: 32];
      end
    end
  end

  // The slave never terminates on a zero operand, so such jobs bypass it.
  assign w_zero       = (w_a == 32'd0) || (w_b == 32'd0);
  assign w_slave_busy = |avm_readdata;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_INIT;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    req_ready = '0;
    case (r_state)
      S_INIT:     w_next = S_INIT_RD;
      S_INIT_RD:  w_next = S_INIT_CHK;
      S_INIT_CHK: begin
        if (!w_slave_busy)      w_next = S_IDLE;
        else if (POLL_GAP == 0) w_next = S_INIT_RD;
        else                    w_next = S_INIT_GAP;
      end
      S_INIT_GAP: if (r_cnt == c_GAP_LAST) w_next = S_INIT_RD;
      S_IDLE: begin
        if (w_found) begin
          req_ready[w_sel] = 1'b1;
          w_next           = w_zero ? S_RESP : S_WR_A;
        end
      end
      S_WR_A:     w_next = S_WR_B;
      S_WR_B:     w_next = S_POLL_RD;
      S_POLL_RD:  w_next = S_POLL_CHK;
      S_POLL_CHK: begin
        if (!w_slave_busy)      w_next = S_RES_RD;
        else if (POLL_GAP == 0) w_next = S_POLL_RD;
        else                    w_next = S_GAP;
      end
      S_GAP:      if (r_cnt == c_GAP_LAST) w_next = S_POLL_RD;
      S_RES_RD:   w_next = S_RES_CHK;
      S_RES_CHK:  w_next = S_RESP;
      S_RESP:     if (rsp_ready) w_next = S_IDLE;
      default:    w_next = S_INIT;
    endcase
  end

  // Bus and status outputs are registered from the next state, so they are
  // cycle-aligned with r_state yet glitch-free and zero while in reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      avm_read      <= 1'b0;
      avm_write     <= 1'b0;
      avm_address   <= '0;
      avm_writedata <= '0;
      rsp_valid     <= 1'b0;
      busy          <= 1'b0;
      jobs_done     <= '0;
      r_ptr         <= ID_W'(NUM_REQ - 1);
      r_id          <= '0;
      r_b           <= '0;
      r_gcd         <= '0;
      r_cnt         <= '0;
    end else begin
      avm_read  <= (w_next == S_INIT_RD) || (w_next == S_POLL_RD) || (w_next == S_RES_RD);
      avm_write <= (w_next == S_WR_A) || (w_next == S_WR_B);
      case (w_next)
        S_WR_A: begin
          avm_address   <= c_ADDR_A;
          avm_writedata <= w_a;          // only reachable from the grant cycle
        end
        S_WR_B: begin
          avm_address   <= c_ADDR_B;
          avm_writedata <= r_b;
        end
        S_RES_RD: begin
          avm_address   <= c_ADDR_A;
          avm_writedata <= '0;
        end
        default: begin
          avm_address   <= c_ADDR_STATUS;
          avm_writedata <= '0;
        end
      endcase
      rsp_valid <= (w_next == S_RESP);
      busy      <= (w_next != S_IDLE);

      if ((r_state == S_IDLE) && w_found) begin
        r_ptr <= w_sel;
        r_id  <= w_sel;
        r_b   <= w_b;
        r_gcd <= w_a | w_b;              // final answer when an operand is zero
      end
      if (r_state == S_RES_CHK) begin
        r_gcd <= avm_readdata;
      end
      if ((r_state == S_RESP) && rsp_ready) begin
        jobs_done <= jobs_done + 16'd1;
      end

      if ((w_next == S_GAP) || (w_next == S_INIT_GAP)) begin
        r_cnt <= ((r_state == S_GAP) || (r_state == S_INIT_GAP)) ? r_cnt + c_GAP_W'(1) : '0;
      end
    end
  end

  assign rsp_id  = r_id;
  assign rsp_gcd = r_gcd;

endmodule
`default_nettype wire

// File: doc/gcd_job_scheduler.md
Name: gcd_job_scheduler

Overview:
Avalon-MM master that shares one 32-bit GCD calculator CSR slave among NUM_REQ requesters. Each requester gets a valid/ready job port; jobs are granted round-robin. For each job the block writes operand A, writes operand B (which starts the computation), polls the status register, reads back the result and returns it on a single tagged response channel. Zero operands are resolved locally because the datapath does not terminate on them.

Parameters:
NUM_REQ, 2, number of requester ports (2..8)
ID_W, $clog2(NUM_REQ), width of the requester tag
POLL_GAP, 4, idle cycles between consecutive status polls (0 = back-to-back)

Ports:
clock  input  1  single clock
reset_n  input  1  asynchronous, active-low reset
req_valid  input  NUM_REQ  per-requester job valid
req_ready  output  NUM_REQ  per-requester job accept; one-hot or zero
req_a  input  32*NUM_REQ  operand A, requester i at [32i+31:32i]
req_b  input  32*NUM_REQ  operand B, same packing
rsp_valid  output  1  result valid
rsp_ready  input  1  result accepted
rsp_id  output  ID_W  index of the requester that owns the result
rsp_gcd  output  32  GCD result
avm_read  output  1  slave read strobe
avm_write  output  1  slave write strobe
avm_address  output  2  0 = status, 1 = A, 2 = B
avm_writedata  output  32  slave write data
avm_readdata  input  32  slave read data, valid the cycle after avm_read
busy  output  1  high in every state except IDLE
jobs_done  output  16  count of responses accepted, wraps at 0xFFFF

Behaviour:
- Reset, asynchronous on reset_n low: state = INIT_POLL; all outputs 0; RR pointer = NUM_REQ-1, so requester 0 has first priority; jobs_done = 0.
- INIT_POLL: the slave ignores writes while busy, so after reset the block waits until status reads 0. Sequence: avm_read with address 0 for 1 cycle, next cycle sample avm_readdata. Nonzero: wait POLL_GAP cycles, repeat. Zero: go to IDLE.
- IDLE: round-robin search starting at ptr+1 mod NUM_REQ. The first i with req_valid[i] gets req_ready[i]=1 for exactly this cycle. On that cycle: capture a, b and id; ptr <= i.
  - a==0 or b==0: result = a|b (covers gcd(0,0)=0). Go to RESP with no bus traffic.
  - Otherwise go to WR_A.
- WR_A: avm_write=1, address 1, writedata a; 1 cycle; -> WR_B.
- WR_B: avm_write=1, address 2, writedata b; 1 cycle; -> POLL_RD.
- POLL_RD: avm_read=1, address 0; 1 cycle; -> POLL_CHK.
- POLL_CHK: sample avm_readdata.
  - Nonzero: -> GAP, or POLL_RD directly if POLL_GAP=0.
  - Zero: -> RES_RD.
  - The first poll after WR_B may legally return 1 even when a==b.
- GAP: counter of POLL_GAP cycles, then -> POLL_RD.
- RES_RD: avm_read=1, address 1; 1 cycle; -> RES_CHK.
- RES_CHK: capture avm_readdata as the result; -> RESP.
- RESP: rsp_valid=1; rsp_id and rsp_gcd held stable until rsp_ready.
  - On rsp_valid & rsp_ready: jobs_done++, -> IDLE.
  - No new grant in the handshake cycle.
- Strobes:
  - avm_read and avm_write are never high together.
  - avm_address and avm_writedata are 0 whenever both strobes are low.
- Minimum job latency, POLL_GAP=0 and a==b nonzero: grant -> WR_A -> WR_B -> POLL_RD -> POLL_CHK (1) -> POLL_RD -> POLL_CHK (0) -> RES_RD -> RES_CHK -> RESP. rsp_valid is therefore asserted 9 cycles after the grant cycle.
- Requester changing req_a/req_b while not granted has no effect. Operands are sampled only in the grant cycle.
- No timeout: a nonzero job runs to completion however long the slave takes.
- busy is low only in IDLE; it is high in INIT_POLL.

Test Plan:
- Requester 0 (48,18), POLL_GAP=0 -> writes in order: addr 1 = 48, then addr 2 = 18. Response rsp_id=0, rsp_gcd=6; jobs_done=1.
- Requester 1 (7,7) -> rsp_gcd=7, rsp_valid exactly 9 cycles after the grant, at least one status read of 1 observed.
- Requester 0 (0,25), then (0,0) -> rsp_gcd=25, then 0. avm_write and avm_read stay 0 throughout.
- All NUM_REQ=2 requesters held valid with distinct jobs (12,8),(35,14) -> grants alternate 0,1,0,1. Results 4,7 tagged with the correct rsp_id; req_ready is never high for two ports at once.
- rsp_ready held low 5 cycles with result 6 pending -> rsp_valid, rsp_id and rsp_gcd stable all 5 cycles. No new req_ready until the handshake; jobs_done increments exactly once.
- reset_n pulsed low mid-job (1000000,1) while the slave stays busy -> outputs 0 immediately. Then status polled until the slave reads 0, no writes before that, and the next job (9,6) returns 3.
